// File: rtl/pulse_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_period_meter
//  Description : Measures the high and low phase lengths, in clock cycles,
//                of a free-running asynchronous signal. One (high, low) pair
//                is published per full period, on the rise that closes it.
//  Ports       : Clock     - single clock, rising edge
//                Reset     - asynchronous, active-high
//                iSignal   - measured signal, asynchronous to Clock
//                iClear    - synchronous clear (input synchronizer untouched)
//                oHigh     - high-phase length of last complete period
//                oLow      - low-phase length of last complete period
//                oValid    - one-cycle pulse, new oHigh/oLow pair
//                oOverflow - sticky, a phase counter saturated
//                oStuck    - current phase counter is saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_meter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iSignal,
    input  logic             iClear,
    output logic [WIDTH-1:0] oHigh,
    output logic [WIDTH-1:0] oLow,
    output logic             oValid,
    output logic             oOverflow,
    output logic             oStuck
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // Input path: synchronizer, one-cycle delayed copy, edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    // Fill marker shifted alongside the synchronizer. Its top bit says the
    // delayed copy holds a genuine sample taken after Reset, so a signal
    // already high at Reset release is not mistaken for a rise.
    logic [SYNC_STAGES:0]   fill_q, fill_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = fill_q[SYNC_STAGES] &  s & ~prev_q;
    assign fall = fill_q[SYNC_STAGES] & ~s &  prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], iSignal};
        prev_d = s;
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // iClear deliberately leaves this path running.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM and datapath
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_hi_q, cnt_hi_d;
    logic [WIDTH-1:0] cnt_lo_q, cnt_lo_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             stuck_q, stuck_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (iClear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_HIGH;
                ST_HIGH: if (fall) state_d = ST_LOW;
                ST_LOW:  if (rise) state_d = ST_HIGH;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counters and published results
    always_comb begin
        cnt_hi_d   = cnt_hi_q;
        cnt_lo_d   = cnt_lo_q;
        hi_lat_d   = hi_lat_q;
        high_d     = high_q;
        low_d      = low_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        stuck_d    = stuck_q;

        if (iClear) begin
            // Takes priority over any edge seen in the same cycle.
            cnt_hi_d   = CNT_ZERO;
            cnt_lo_d   = CNT_ZERO;
            hi_lat_d   = CNT_ZERO;
            high_d     = CNT_ZERO;
            low_d      = CNT_ZERO;
            overflow_d = 1'b0;
            stuck_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_hi_d = CNT_ZERO;
                    cnt_lo_d = CNT_ZERO;
                    stuck_d  = 1'b0;
                    // First rise only starts a measurement; nothing to publish.
                    if (rise) cnt_hi_d = CNT_ONE;
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_lat_d = cnt_hi_q;
                        cnt_lo_d = CNT_ONE;
                        stuck_d  = 1'b0;
                    end else if (s) begin
                        cnt_hi_d   = sat_inc(cnt_hi_q);
                        stuck_d    = (cnt_hi_d == CNT_MAX);
                        overflow_d = overflow_q | stuck_d;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_d   = hi_lat_q;
                        low_d    = cnt_lo_q;
                        valid_d  = 1'b1;
                        cnt_hi_d = CNT_ONE;
                        stuck_d  = 1'b0;
                    end else if (!s) begin
                        cnt_lo_d   = sat_inc(cnt_lo_q);
                        stuck_d    = (cnt_lo_d == CNT_MAX);
                        overflow_d = overflow_q | stuck_d;
                    end
                end
                default: begin
                    cnt_hi_d = CNT_ZERO;
                    cnt_lo_d = CNT_ZERO;
                    stuck_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_hi_q   <= '0;
            cnt_lo_q   <= '0;
            hi_lat_q   <= '0;
            high_q     <= '0;
            low_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            cnt_hi_q   <= cnt_hi_d;
            cnt_lo_q   <= cnt_lo_d;
            hi_lat_q   <= hi_lat_d;
            high_q     <= high_d;
            low_q      <= low_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            stuck_q    <= stuck_d;
        end
    end

    assign oHigh     = high_q;
    assign oLow      = low_q;
    assign oValid    = valid_q;
    assign oOverflow = overflow_q;
    assign oStuck    = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_period_meter
//  Description : Self-checking bench for pulse_period_meter. A run-length
//                reference model predicts every output on every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_period_meter;

    localparam int WIDTH = 8;
    localparam int S     = 2;
    localparam int MAX   = (1 << WIDTH) - 1;

    logic             Clock   = 1'b0;
    logic             Reset   = 1'b1;
    logic             iSignal = 1'b0;
    logic             iClear  = 1'b0;
    logic [WIDTH-1:0] oHigh;
    logic [WIDTH-1:0] oLow;
    logic             oValid;
    logic             oOverflow;
    logic             oStuck;

    pulse_period_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(S)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iSignal  (iSignal),
        .iClear   (iClear),
        .oHigh    (oHigh),
        .oLow     (oLow),
        .oValid   (oValid),
        .oOverflow(oOverflow),
        .oStuck   (oStuck)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------------
    // Reference model: samples since reset, plus run lengths
    // ---------------------------------------------------------------
    bit hist[$];
    bit armed;
    bit have_hi;
    int run_len;
    int hi_len;
    int exp_high, exp_low;
    bit exp_valid, exp_ovf, exp_stuck;
    int n_pub;
    int obs_pub;

    function automatic int sat(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        armed = 0; have_hi = 0; run_len = 0; hi_len = 0;
        exp_high = 0; exp_low = 0;
        exp_valid = 0; exp_ovf = 0; exp_stuck = 0;
    endfunction

    // One clock edge: the logic sees the sample taken S edges ago and the
    // one before it (only if both were taken after reset).
    function automatic void model_edge(input bit sig, input bit clr);
        int j = hist.size();
        bit sv, pv, pval, rise, fall;
        sv   = (j >= S) ? hist[j-S] : 1'b0;
        pval = (j >= S + 1);
        pv   = pval ? hist[j-S-1] : 1'b0;
        hist.push_back(sig);
        rise = pval && sv && !pv;
        fall = pval && !sv && pv;
        exp_valid = 0;
        if (clr) begin
            armed = 0; have_hi = 0; run_len = 0;
            exp_high = 0; exp_low = 0; exp_ovf = 0; exp_stuck = 0;
            return;
        end
        if (rise) begin
            if (armed && have_hi) begin
                exp_high  = sat(hi_len);
                exp_low   = sat(run_len);
                exp_valid = 1;
                n_pub++;
            end
            armed = 1; have_hi = 0; run_len = 1;
        end else if (fall) begin
            if (armed) begin
                hi_len = run_len; have_hi = 1; run_len = 1;
            end
        end else if (armed) begin
            run_len++;
        end
        exp_stuck = armed && (run_len >= MAX);
        if (exp_stuck) exp_ovf = 1;
    endfunction

    // True if the coming edge will see a rise that closes a full period.
    function automatic bit pub_next();
        int j = hist.size();
        if (j < S + 1) return 0;
        return armed && have_hi && hist[j-S] && !hist[j-S-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge(iSignal, iClear);
        #1;
        chk("valid",    {31'd0, oValid},    {31'd0, exp_valid});
        chk("high",     {24'd0, oHigh},     exp_high);
        chk("low",      {24'd0, oLow},      exp_low);
        chk("overflow", {31'd0, oOverflow}, {31'd0, exp_ovf});
        chk("stuck",    {31'd0, oStuck},    {31'd0, exp_stuck});
        if (oValid === 1'b1) obs_pub++;
    endtask

    task automatic cycle(input logic v, input logic clr, input bit glitch);
        iClear  = clr;
        iSignal = v;
        // Sub-cycle pulse well away from the sampling edge.
        if (glitch && $urandom_range(0, 5) == 0) begin
            iSignal = ~v; #2; iSignal = v;
        end
        tick();
        iClear = 1'b0;
    endtask

    task automatic run_level(input logic v, input int n, input bit glitch);
        for (int i = 0; i < n; i++) cycle(v, 1'b0, glitch);
    endtask

    // Called one time unit after an edge: reset lands between edges.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_valid",    {31'd0, oValid},    0);
        chk("rst_high",     {24'd0, oHigh},     0);
        chk("rst_low",      {24'd0, oLow},      0);
        chk("rst_overflow", {31'd0, oOverflow}, 0);
        chk("rst_stuck",    {31'd0, oStuck},    0);
        repeat (2) @(posedge Clock);
        #3;
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        n_pub = 0; obs_pub = 0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        chk("init_valid",    {31'd0, oValid},    0);
        chk("init_high",     {24'd0, oHigh},     0);
        chk("init_overflow", {31'd0, oOverflow}, 0);
        #2;
        Reset = 1'b0;

        // 3 high / 5 low periodic
        for (int k = 0; k < 6; k++) begin
            run_level(1'b1, 3, 1'b0);
            run_level(1'b0, 5, 1'b0);
        end
        chk("p35_high", {24'd0, oHigh}, 3);
        chk("p35_low",  {24'd0, oLow},  5);

        // toggle every cycle
        for (int k = 0; k < 40; k++) cycle(k[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        chk("tog_high",  {24'd0, oHigh},     1);
        chk("tog_low",   {24'd0, oLow},      1);
        chk("tog_stuck", {31'd0, oStuck},    0);

        // long high phase saturates
        run_level(1'b1, 300, 1'b0);
        chk("sat_stuck",    {31'd0, oStuck},    1);
        chk("sat_overflow", {31'd0, oOverflow}, 1);
        run_level(1'b0, 4, 1'b0);
        run_level(1'b1, 3, 1'b0);
        chk("sat_high",     {24'd0, oHigh},     255);
        chk("sat_low",      {24'd0, oLow},      4);
        chk("sat_unstuck",  {31'd0, oStuck},    0);
        chk("sat_sticky",   {31'd0, oOverflow}, 1);

        // asynchronous reset in the middle of a high phase
        run_level(1'b0, 5, 1'b0);
        run_level(1'b1, 2, 1'b0);
        do_reset();
        run_level(1'b1, 3, 1'b0);
        run_level(1'b0, 3, 1'b0);
        run_level(1'b1, 3, 1'b0);
        chk("rmid_nopub", {24'd0, oHigh}, 0);
        run_level(1'b0, 3, 1'b0);
        run_level(1'b1, 4, 1'b0);
        chk("rmid_high", {24'd0, oHigh}, 3);
        chk("rmid_low",  {24'd0, oLow},  3);

        // clear on the very edge of a publishing rise
        done = 0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 5; i++) begin
                logic lv;
                bit   hit;
                lv  = (i < 2) ? 1'b1 : 1'b0;
                hit = !done && pub_next();
                cycle(lv, hit, 1'b0);
                if (hit) begin
                    done = 1;
                    chk("clr_valid", {31'd0, oValid}, 0);
                    chk("clr_high",  {24'd0, oHigh},  0);
                    chk("clr_low",   {24'd0, oLow},   0);
                end
            end
        end
        chk("clr_after_high", {24'd0, oHigh}, 2);
        chk("clr_after_low",  {24'd0, oLow},  3);

        // signal already high through reset release
        iSignal = 1'b1;
        do_reset();
        run_level(1'b1, 5, 1'b0);
        run_level(1'b0, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_level(1'b1, 4, 1'b0);
            if (k == 0) chk("hirst_nopub", {24'd0, oHigh}, 0);
            run_level(1'b0, 2, 1'b0);
        end
        chk("hirst_high", {24'd0, oHigh}, 4);
        chk("hirst_low",  {24'd0, oLow},  2);

        // randomized phases with glitches, occasional clears and long runs
        for (int k = 0; k < 150; k++) begin
            int h, l;
            h = ($urandom_range(0, 29) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 12);
            l = ($urandom_range(0, 29) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 12);
            run_level(1'b1, h, 1'b1);
            if ($urandom_range(0, 19) == 0) cycle(1'b1, 1'b1, 1'b0);
            run_level(1'b0, l, 1'b1);
        end
        run_level(1'b1, 4, 1'b0);

        chk("pub_count", obs_pub, n_pub);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
